// File: rtl/imuldiv_booth_pkg.sv
// imuldiv_booth_pkg: shared FSM states, Booth digit codes and iteration count for the radix-4 multiplier
package imuldiv_booth_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  localparam logic [2:0] D_ZERO = 3'd0;
  localparam logic [2:0] D_POS1 = 3'd1;
  localparam logic [2:0] D_POS2 = 3'd2;
  localparam logic [2:0] D_NEG1 = 3'd3;
  localparam logic [2:0] D_NEG2 = 3'd4;
  function automatic int booth_iters(input int width);
    return (width + 2) / 2;
  endfunction
endpackage

// File: rtl/imuldiv_booth_r4_enc.sv
// imuldiv_booth_r4_enc: recodes one Booth triplet into a signed partial product of the multiplicand
module imuldiv_booth_r4_enc
  import imuldiv_booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]              trip_i,
  input  logic [WIDTH+1:0]        a_i,
  output logic signed [WIDTH+2:0] pp_o
);
  logic [2:0]       dig;
  logic [WIDTH+2:0] a1, a2;
  assign a1 = {a_i[WIDTH+1], a_i};
  assign a2 = {a_i, 1'b0};
  always_comb begin
    dig = (trip_i == 3'b001 || trip_i == 3'b010) ? D_POS1 :
          (trip_i == 3'b011)                     ? D_POS2 :
          (trip_i == 3'b100)                     ? D_NEG2 :
          (trip_i == 3'b101 || trip_i == 3'b110) ? D_NEG1 : D_ZERO;
    pp_o = (dig == D_POS1) ? a1 :
           (dig == D_POS2) ? a2 :
           (dig == D_NEG1) ? -a1 :
           (dig == D_NEG2) ? -a2 : '0;
  end
endmodule

// File: rtl/imuldiv_int_mul_booth_r4.sv
// imuldiv_int_mul_booth_r4: iterative radix-4 Booth multiplier behind a val/rdy request/response interface
module imuldiv_int_mul_booth_r4
  import imuldiv_booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   mulreq_msg_a,
  input  logic [WIDTH-1:0]   mulreq_msg_b,
  input  logic               mulreq_msg_signed,
  input  logic               mulreq_val,
  output logic               mulreq_rdy,
  output logic [2*WIDTH-1:0] mulresp_msg_result,
  output logic               mulresp_val,
  input  logic               mulresp_rdy
);
  localparam int N  = booth_iters(WIDTH);
  localparam int E  = WIDTH + 2;
  localparam int AW = WIDTH + 3;
  localparam int PW = AW + E + 1;
  localparam int CW = $clog2(N + 1);
  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [E-1:0]    a_q, a_ext, b_ext;
  logic [PW-1:0]   p_q, p_d;
  logic [AW-1:0]   pp, sum;
  assign a_ext = {{2{mulreq_msg_signed & mulreq_msg_a[WIDTH-1]}}, mulreq_msg_a};
  assign b_ext = {{2{mulreq_msg_signed & mulreq_msg_b[WIDTH-1]}}, mulreq_msg_b};
  imuldiv_booth_r4_enc #(.WIDTH(WIDTH)) u_enc (
    .trip_i (p_q[2:0]),
    .a_i    (a_q),
    .pp_o   (pp)
  );
  // p_q = {acc, multiplier, implicit 0}; the product settles one bit above the LSB
  assign sum                = p_q[PW-1 -: AW] + pp;
  assign p_d                = {{2{sum[AW-1]}}, sum, p_q[E:2]};
  assign mulresp_msg_result = p_q[2*WIDTH:1];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      p_q         <= '0;
      mulreq_rdy  <= 1'b1;
      mulresp_val <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (mulreq_val && mulreq_rdy) begin
          a_q        <= a_ext;
          p_q        <= {{AW{1'b0}}, b_ext, 1'b0};
          cnt_q      <= '0;
          state_q    <= CALC;
          mulreq_rdy <= 1'b0;
        end
        CALC: begin
          p_q   <= p_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            state_q     <= DONE;
            mulresp_val <= 1'b1;
          end
        end
        DONE: if (mulresp_rdy) begin
          state_q     <= IDLE;
          mulresp_val <= 1'b0;
          mulreq_rdy  <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          mulreq_rdy  <= 1'b1;
          mulresp_val <= 1'b0;
        end
      endcase
    end
  end
endmodule
